// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs, Irq line,
// and the pipeline enables/flushes driven back to the core.
interface hazard_ctrl_if;
  logic       Irq;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRt;
  logic [2:0] ID_PCSrc;
  logic       ID_Eret;
  logic       ID_Valid;
  logic       EX_MemRd;
  logic [4:0] EX_Rt;
  logic       EX_BranchTaken;
  logic       PCWr;
  logic       IF_ID_Wr;
  logic       IF_ID_flush_n;
  logic       ID_EX_flush_n;
  logic       IrqTake;
  logic       IrqMasked;

  modport master (
    output Irq, ID_Rs, ID_Rt, ID_UsesRt,
    output ID_PCSrc, ID_Eret, ID_Valid,
    output EX_MemRd, EX_Rt, EX_BranchTaken,
    input  PCWr, IF_ID_Wr, IF_ID_flush_n,
    input  ID_EX_flush_n, IrqTake, IrqMasked
  );

  modport slave (
    input  Irq, ID_Rs, ID_Rt, ID_UsesRt,
    input  ID_PCSrc, ID_Eret, ID_Valid,
    input  EX_MemRd, EX_Rt, EX_BranchTaken,
    output PCWr, IF_ID_Wr, IF_ID_flush_n,
    output ID_EX_flush_n, IrqTake, IrqMasked
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch / jump hazard control plus interrupt entry,
// kernel masking and post-ERET holdoff. Ports: clk, reset (async low), hz.
module hazard_ctrl #(
  parameter int unsigned HOLDOFF = 2
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    KERNEL = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LD = 4'(HOLDOFF);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] arm_q, arm_d;
  logic       s1_q, s2_q, s3_q;
  logic       pend_q, pend_d;

  logic br, lu, jmp, take, eret_ok, rise;

  always_comb begin
    br  = hz.EX_BranchTaken;
    lu  = hz.EX_MemRd
        && (hz.EX_Rt != 5'd0)
        && ((hz.EX_Rt == hz.ID_Rs)
        ||  (hz.ID_UsesRt
        &&   hz.EX_Rt == hz.ID_Rt));
    jmp = (hz.ID_PCSrc == 3'b010)
       || (hz.ID_PCSrc == 3'b011);
    take = !br && !lu
        && (state_q == RUN)
        && pend_q
        && hz.ID_Valid
        && (hz.ID_PCSrc == 3'b000)
        && !hz.ID_Eret;
    // A flushed or stalled ERET has not retired yet.
    eret_ok = !br && !lu && hz.ID_Eret;
    // Edge detect is blind until the chain has seen
    // three samples, so a level held across reset is ignored.
    rise = s2_q && !s3_q && (arm_q == 2'd3);
  end

  always_comb begin
    hz.PCWr          = 1'b1;
    hz.IF_ID_Wr      = 1'b1;
    hz.IF_ID_flush_n = 1'b1;
    hz.ID_EX_flush_n = 1'b1;
    hz.IrqTake       = 1'b0;
    priority case (1'b1)
      br: begin
        hz.IF_ID_flush_n = 1'b0;
        hz.ID_EX_flush_n = 1'b0;
      end
      lu: begin
        hz.PCWr          = 1'b0;
        hz.IF_ID_Wr      = 1'b0;
        hz.ID_EX_flush_n = 1'b0;
      end
      take: begin
        hz.IrqTake       = 1'b1;
        hz.IF_ID_flush_n = 1'b0;
      end
      jmp: begin
        hz.IF_ID_flush_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign hz.IrqMasked = (state_q != RUN);

  always_comb begin
    arm_d  = (arm_q == 2'd3) ? arm_q
                             : arm_q + 2'd1;
    // Set wins over the clear from a take.
    pend_d = (pend_q && !take) || rise;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (take) state_d = KERNEL;
      end
      KERNEL: begin
        if (eret_ok) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_q <= 4'd1) begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      arm_q   <= 2'd0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      s1_q    <= hz.Irq;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then
// randomized traffic, checked against a behavioural model.
module tb_hazard_ctrl;

  localparam int HO = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.HOLDOFF(HO)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  logic [5:0] sb[$];
  int nvec = 0;
  int nerr = 0;
  int ncyc = 0;
  int ntake = 0;

  // Stimulus for the next cycle.
  logic       t_rst = 1'b0;
  logic       t_irq = 1'b0;
  logic [4:0] t_rs = '0, t_rt = '0, t_exrt = '0;
  logic       t_usert = 1'b0, t_eret = 1'b0;
  logic       t_valid = 1'b1, t_memrd = 1'b0;
  logic       t_br = 1'b0;
  logic [2:0] t_pcsrc = '0;

  // Model state.
  bit m_kernel, m_pend, m_prev;
  int m_hold, m_n;
  int m_arr[$];
  bit p_rst, p_irq, p_take, p_eret;

  function automatic void model_reset();
    m_kernel = 0;
    m_pend   = 0;
    m_prev   = 0;
    m_hold   = 0;
    m_n      = 0;
    m_arr.delete();
  endfunction

  // Advance the model across one rising edge.
  function automatic void model_edge();
    bit np;
    if (!p_rst) return;
    m_n++;
    np = m_pend && !p_take;
    if (m_arr.size() > 0 && m_arr[0] == m_n) begin
      void'(m_arr.pop_front());
      np = 1;
    end
    // An Irq rise seen at edge k shows as pend after edge k+2.
    if (m_n >= 2 && p_irq && !m_prev)
      m_arr.push_back(m_n + 2);
    m_prev = p_irq;
    m_pend = np;
    if (p_take) m_kernel = 1;
    else if (m_kernel && p_eret) begin
      m_kernel = 0;
      m_hold   = HO;
    end else if (m_hold > 0) m_hold--;
  endfunction

  task automatic cyc();
    bit br, lu, jmp, masked, take;
    logic [5:0] e;
    @(negedge clk);
    model_edge();
    reset              = t_rst;
    hif.Irq            = t_irq;
    hif.ID_Rs          = t_rs;
    hif.ID_Rt          = t_rt;
    hif.ID_UsesRt      = t_usert;
    hif.ID_PCSrc       = t_pcsrc;
    hif.ID_Eret        = t_eret;
    hif.ID_Valid       = t_valid;
    hif.EX_MemRd       = t_memrd;
    hif.EX_Rt          = t_exrt;
    hif.EX_BranchTaken = t_br;
    if (!t_rst) model_reset();
    br = t_br;
    lu = t_memrd && t_exrt != 0 &&
         (t_exrt == t_rs || (t_usert && t_exrt == t_rt));
    jmp = t_pcsrc == 3'd2 || t_pcsrc == 3'd3;
    masked = m_kernel || m_hold > 0;
    take = !br && !lu && !masked && m_pend &&
           t_valid && t_pcsrc == 3'd0 && !t_eret;
    if (br)        e = 6'b11_00_0;
    else if (lu)   e = 6'b00_10_0;
    else if (take) e = 6'b11_01_1;
    else if (jmp)  e = 6'b11_01_0;
    else           e = 6'b11_11_0;
    e = {e[4:0], masked};
    sb.push_back(e);
    if (take) ntake++;
    p_rst  = t_rst;
    p_irq  = t_irq;
    p_take = take;
    p_eret = !br && !lu && t_eret;
    ncyc++;
  endtask

  task automatic clr();
    t_rs = 0; t_rt = 0; t_exrt = 0;
    t_usert = 0; t_eret = 0; t_valid = 1;
    t_memrd = 0; t_br = 0; t_pcsrc = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Monitor: outputs are presented every cycle.
  initial begin
    logic [5:0] a, x;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        a = {hif.PCWr, hif.IF_ID_Wr,
             hif.IF_ID_flush_n, hif.ID_EX_flush_n,
             hif.IrqTake, hif.IrqMasked};
        nvec++;
        if (a !== x) begin
          nerr++;
          $display("FAIL outs cyc=%0d got=%b exp=%b",
                   nvec, a, x);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout nvec=%0d", nvec);
    $fatal(1, "timeout");
  end

  initial begin
    p_rst = 0;
    model_reset();
    clr();
    t_rst = 0;
    run(3);
    t_rst = 1;
    run(4);
    // Load-use then no-stall with Rt=0.
    t_memrd = 1; t_exrt = 8; t_rs = 8;
    cyc();
    t_memrd = 0;
    cyc();
    t_memrd = 1; t_exrt = 0; t_rs = 0;
    cyc();
    // Branch and load-use together.
    t_br = 1; t_exrt = 8; t_rs = 8;
    cyc();
    clr();
    // Interrupt entry, then a second edge in kernel.
    t_irq = 1; run(6);
    t_irq = 0; run(3);
    t_irq = 1; run(6);
    // Return, holdoff, pending taken.
    t_eret = 1; cyc();
    t_eret = 0; run(5);
    t_eret = 1; cyc();
    t_eret = 0; run(4);
    // Deferral behind a jump.
    t_irq = 0; run(3);
    t_irq = 1; t_pcsrc = 3'd2; run(5);
    t_pcsrc = 0; run(3);
    // Reset while in kernel with pend set.
    t_irq = 0; run(3);
    t_irq = 1; run(5);
    t_rst = 0; run(2);
    t_rst = 1; run(6);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (t_rst == 0) t_rst = 1;
      else if ($urandom_range(0, 399) == 0) t_rst = 0;
      if ($urandom_range(0, 11) == 0) t_irq = ~t_irq;
      t_rs    = 5'($urandom_range(0, 3));
      t_rt    = 5'($urandom_range(0, 3));
      t_exrt  = 5'($urandom_range(0, 3));
      t_usert = 1'($urandom_range(0, 1));
      t_memrd = $urandom_range(0, 3) == 0;
      t_br    = $urandom_range(0, 7) == 0;
      t_eret  = $urandom_range(0, 15) == 0;
      t_valid = $urandom_range(0, 9) != 0;
      t_pcsrc = ($urandom_range(0, 9) < 7) ? 3'd0
              : 3'($urandom_range(1, 3));
      cyc();
    end
    clr();
    run(2);
    repeat (2) @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    if (ntake == 0) begin
      nerr++;
      $display("FAIL irq_takes got=0 exp>0");
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
